// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared types and helpers for the fetch/data memory arbiter.
package riscv_mem_arbiter_pkg;

    // Access size encoding as presented on d_size
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RD_CAP,
        ST_RMW_RD,
        ST_RMW_MRG,
        ST_WR
    } state_e;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

    // Little-endian byte lanes: lane n holds bits [8n+7:8n]
    localparam logic [3:0] LANE_0 = 4'b0001;
    localparam logic [3:0] LANE_1 = 4'b0010;
    localparam logic [3:0] LANE_2 = 4'b0100;
    localparam logic [3:0] LANE_3 = 4'b1000;

    // Byte lanes touched by an access of the given size at byte offset offs
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offs);
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = LANE_0 << offs;
            SZ_HALF: m = (LANE_0 | LANE_1) << offs;
            SZ_WORD: m = LANE_0 | LANE_1 | LANE_2 | LANE_3;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Illegal size or an address not aligned to the access size
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] offs);
        logic e;
        case (size)
            SZ_BYTE: e = 1'b0;
            SZ_HALF: e = offs[0];
            SZ_WORD: e = (offs != 2'b00);
            default: e = 1'b1;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle between the core ports, the arbiter and the unified memory.
interface riscv_mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    // fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [31:0]       if_rdata;
    logic              if_err;
    // load/store port
    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic              d_uns;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_valid;
    logic [31:0]       d_rdata;
    logic              d_err;
    // memory side
    logic              mem_en;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    // core / requester view
    modport master (
        output if_req, if_addr, d_req, d_we, d_size, d_uns, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_valid, if_rdata, if_err, d_gnt, d_valid, d_rdata, d_err,
               mem_en, mem_rw, mem_addr, mem_wdata
    );

    // arbiter view
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_size, d_uns, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_valid, if_rdata, if_err, d_gnt, d_valid, d_rdata, d_err,
               mem_en, mem_rw, mem_addr, mem_wdata
    );

    // memory view
    modport mem (
        input  mem_en, mem_rw, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/riscv_mem_arbiter_lane_align.sv
// Combinational sub-word handling: load lane extract/extend and store lane merge.
module riscv_mem_arbiter_lane_align
    import riscv_mem_arbiter_pkg::*;
(
    input  logic [31:0] i_word,    // word read from memory
    input  logic [31:0] i_wdata,   // right-justified store data
    input  size_e       i_size,
    input  logic        i_uns,
    input  logic [1:0]  i_offs,    // byte offset within the word
    output logic [31:0] o_load,    // aligned, extended load result
    output logic [31:0] o_merged   // i_word with the addressed lanes replaced
);
    logic [31:0] w_shifted;
    logic [31:0] w_repl;
    logic [3:0]  w_mask;

    // Shift the addressed lane down to bit 0, then sign/zero extend
    always_comb begin
        w_shifted = i_word >> {i_offs, 3'b000};
        case (i_size)
            SZ_BYTE: o_load = {{24{~i_uns & w_shifted[7]}},  w_shifted[7:0]};
            SZ_HALF: o_load = {{16{~i_uns & w_shifted[15]}}, w_shifted[15:0]};
            default: o_load = i_word;
        endcase
    end

    // Replicate store data across all lanes so the mask alone selects placement
    always_comb begin
        case (i_size)
            SZ_BYTE: w_repl = {4{i_wdata[7:0]}};
            SZ_HALF: w_repl = {2{i_wdata[15:0]}};
            default: w_repl = i_wdata;
        endcase
        w_mask   = lane_mask(i_size, i_offs);
        o_merged = i_word;
        for (int n = 0; n < 4; n++) begin
            if (w_mask[n]) o_merged[8*n +: 8] = w_repl[8*n +: 8];
        end
    end
endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one single-ported synchronous memory between fetch and load/store ports.
// Grants in IDLE only, one transaction in flight, sub-word stores done as RMW.
module riscv_mem_arbiter
    import riscv_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_PRIO = 0
)(
    input logic             clk,
    input logic             rst_n,
    riscv_mem_arbiter_if.slave bus
);
    state_e            r_state;
    logic              r_last_data;   // 1: data port held the most recent grant
    port_e             r_port;
    logic [ADDR_W-1:0] r_addr;
    size_e             r_size;
    logic              r_uns;
    logic [31:0]       r_wdata;

    logic              r_if_valid, r_if_err;
    logic [31:0]       r_if_rdata;
    logic              r_d_valid, r_d_err;
    logic [31:0]       r_d_rdata;
    logic              r_mem_en, r_mem_rw;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;

    logic              w_idle;
    logic              w_pick_data;
    logic              w_if_gnt, w_d_gnt;
    logic [ADDR_W-1:0] w_req_addr;
    size_e             w_req_size;
    logic              w_req_we;
    logic              w_req_err;
    logic [31:0]       w_load, w_merged;

    // Arbitration: on a tie either data always wins, or the port not granted last wins
    assign w_idle      = (r_state == ST_IDLE);
    assign w_pick_data = (bus.if_req && bus.d_req) ? ((DATA_PRIO != 0) || !r_last_data)
                                                   : bus.d_req;
    assign w_d_gnt     = w_idle && bus.d_req  &&  w_pick_data;
    assign w_if_gnt    = w_idle && bus.if_req && !w_pick_data;

    // Fields of whichever request is being granted this cycle; fetch is a word load
    assign w_req_addr = w_d_gnt ? bus.d_addr : bus.if_addr;
    assign w_req_size = w_d_gnt ? size_e'(bus.d_size) : SZ_WORD;
    assign w_req_we   = w_d_gnt && bus.d_we;
    assign w_req_err  = w_d_gnt ? access_err(bus.d_size, bus.d_addr[1:0])
                                : (bus.if_addr[1:0] != 2'b00);

    riscv_mem_arbiter_lane_align u_align (
        .i_word   (bus.mem_rdata),
        .i_wdata  (r_wdata),
        .i_size   (r_size),
        .i_uns    (r_uns),
        .i_offs   (r_addr[1:0]),
        .o_load   (w_load),
        .o_merged (w_merged)
    );

    // Sequencer: all outputs are registered single-cycle pulses, cleared by default
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_last_data <= 1'b1;
            r_port      <= PORT_FETCH;
            r_addr      <= '0;
            r_size      <= SZ_WORD;
            r_uns       <= 1'b0;
            r_wdata     <= '0;
            r_if_valid  <= 1'b0;
            r_if_err    <= 1'b0;
            r_if_rdata  <= '0;
            r_d_valid   <= 1'b0;
            r_d_err     <= 1'b0;
            r_d_rdata   <= '0;
            r_mem_en    <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_if_valid  <= 1'b0;
            r_if_err    <= 1'b0;
            r_if_rdata  <= '0;
            r_d_valid   <= 1'b0;
            r_d_err     <= 1'b0;
            r_d_rdata   <= '0;
            r_mem_en    <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_if_gnt || w_d_gnt) begin
                        r_last_data <= w_d_gnt;
                        r_port      <= w_d_gnt ? PORT_DATA : PORT_FETCH;
                        r_addr      <= w_req_addr;
                        r_size      <= w_req_size;
                        r_uns       <= w_d_gnt && bus.d_uns;
                        r_wdata     <= bus.d_wdata;
                        if (w_req_err) begin
                            // rejected without touching memory, answered next cycle
                            if (w_d_gnt) begin
                                r_d_valid <= 1'b1;
                                r_d_err   <= 1'b1;
                            end else begin
                                r_if_valid <= 1'b1;
                                r_if_err   <= 1'b1;
                            end
                        end else begin
                            r_mem_en   <= 1'b1;
                            r_mem_addr <= {w_req_addr[ADDR_W-1:2], 2'b00};
                            if (!w_req_we) begin
                                r_state <= ST_RD;
                            end else if (w_req_size == SZ_WORD) begin
                                r_state     <= ST_WR;
                                r_mem_rw    <= 1'b1;
                                r_mem_wdata <= bus.d_wdata;
                            end else begin
                                r_state <= ST_RMW_RD;
                            end
                        end
                    end
                end
                ST_RD: begin
                    r_state <= ST_RD_CAP;
                end
                ST_RD_CAP: begin
                    r_state <= ST_IDLE;
                    if (r_port == PORT_DATA) begin
                        r_d_valid <= 1'b1;
                        r_d_rdata <= w_load;
                    end else begin
                        r_if_valid <= 1'b1;
                        r_if_rdata <= w_load;
                    end
                end
                ST_RMW_RD: begin
                    r_state <= ST_RMW_MRG;
                end
                ST_RMW_MRG: begin
                    r_state     <= ST_WR;
                    r_mem_en    <= 1'b1;
                    r_mem_rw    <= 1'b1;
                    r_mem_addr  <= {r_addr[ADDR_W-1:2], 2'b00};
                    r_mem_wdata <= w_merged;
                end
                ST_WR: begin
                    r_state   <= ST_IDLE;
                    r_d_valid <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.if_gnt    = w_if_gnt;
    assign bus.d_gnt     = w_d_gnt;
    assign bus.if_valid  = r_if_valid;
    assign bus.if_err    = r_if_err;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_valid   = r_d_valid;
    assign bus.d_err     = r_d_err;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_rw    = r_mem_rw;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: directed vector table, corner sequences and a
// randomized run against a word-array reference model.
module tb_riscv_mem_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    riscv_mem_arbiter_if #(.ADDR_W(32)) bus0();
    riscv_mem_arbiter_if #(.ADDR_W(32)) bus1();

    riscv_mem_arbiter #(.ADDR_W(32), .DATA_PRIO(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    riscv_mem_arbiter #(.ADDR_W(32), .DATA_PRIO(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory behind dut0, with a backdoor write port used for preloading
    logic [31:0] mem0 [0:1023];
    logic        bd_we;
    logic [9:0]  bd_idx;
    logic [31:0] bd_data;
    always @(posedge clk) begin
        if (bd_we) mem0[bd_idx] <= bd_data;
        else if (bus0.mem_en) begin
            if (bus0.mem_rw) mem0[bus0.mem_addr[11:2]] <= bus0.mem_wdata;
            else             bus0.mem_rdata <= mem0[bus0.mem_addr[11:2]];
        end
    end
    assign bus1.mem_rdata = 32'h0;

    // protocol monitor on dut0
    always @(negedge clk) begin
        if (rst_n && (bus0.if_valid || bus0.d_valid)) begin
            checks++;
            if (bus0.if_valid && bus0.d_valid) begin
                failures++;
                $display("FAIL both_valid if_valid=%0b d_valid=%0b required one-hot", bus0.if_valid, bus0.d_valid);
            end
        end
        if (rst_n && bus0.mem_en && !bus0.mem_rw) begin
            checks++;
            if (bus0.mem_wdata !== 32'h0) begin
                failures++;
                $display("FAIL rd_wdata got=%h required=00000000", bus0.mem_wdata);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] v);
        bd_we = 1'b1; bd_idx = idx[9:0]; bd_data = v;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic idle_inputs();
        bus0.if_req = 0; bus0.if_addr = '0; bus0.d_req = 0; bus0.d_we = 0;
        bus0.d_size = 2'b10; bus0.d_uns = 0; bus0.d_addr = '0; bus0.d_wdata = '0;
        bus1.if_req = 0; bus1.if_addr = '0; bus1.d_req = 0; bus1.d_we = 0;
        bus1.d_size = 2'b10; bus1.d_uns = 0; bus1.d_addr = '0; bus1.d_wdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // One transaction on dut0; enm bit k = mem_en in cycle T+k, ww = last write word
    task automatic txn(input bit fe, input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output bit er,
                       output logic [7:0] enm, output logic [31:0] ww);
        bit got;
        got = 0; lat = 0; rd = '0; er = 0; enm = '0; ww = '0;
        if (fe) begin
            bus0.if_req = 1; bus0.if_addr = addr;
        end else begin
            bus0.d_req = 1; bus0.d_we = we; bus0.d_size = sz; bus0.d_uns = uns;
            bus0.d_addr = addr; bus0.d_wdata = wd;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = fe ? bus0.if_gnt : bus0.d_gnt;
        end
        if (got) enm[0] = bus0.mem_en;
        @(posedge clk); #1;
        bus0.if_req = 0; bus0.d_req = 0;
        if (!got) begin
            checks++; failures++;
            $display("FAIL grant_timeout addr=%h got=none required=grant", addr);
            return;
        end
        for (int k = 1; k < 8 && lat == 0; k++) begin
            @(negedge clk);
            enm[k] = bus0.mem_en;
            if (bus0.mem_en && bus0.mem_rw) ww = bus0.mem_wdata;
            if (fe ? bus0.if_valid : bus0.d_valid) begin
                lat = k;
                rd  = fe ? bus0.if_rdata : bus0.d_rdata;
                er  = fe ? bus0.if_err   : bus0.d_err;
            end
        end
        @(posedge clk); #1;
    endtask

    // reference model: plain arithmetic on a word array
    logic [31:0] ref_mem [0:63];

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                             input bit uns, input int off);
        logic [31:0] s;
        s = w >> (8 * off);
        if (sz == 2'b00) begin
            s = s & 32'hFF;
            if (!uns && s >= 32'h80) s = s | 32'hFFFFFF00;
        end else if (sz == 2'b01) begin
            s = s & 32'hFFFF;
            if (!uns && s >= 32'h8000) s = s | 32'hFFFF0000;
        end
        return s;
    endfunction

    function automatic bit ref_err(input logic [1:0] sz, input int addr);
        return (sz == 2'b11) || (sz == 2'b01 && addr % 2 != 0) || (sz == 2'b10 && addr % 4 != 0);
    endfunction

    typedef struct {
        bit          we;
        logic [1:0]  sz;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] pre;
        logic [31:0] erd;
        bit          eer;
        int          elat;
        logic [7:0]  eenm;
        logic [31:0] eww;
    } vec_t;
    vec_t vt [12];

    int          lat, n0, n1, nif1, c0a, c0b, c1a, c1b, nv, ne;
    logic [31:0] rd, ww, expd, w;
    bit          er, got, fe, we, uns, eer;
    logic [7:0]  enm;
    logic [5:0]  seq0, seq1;
    logic [1:0]  sz;
    int          a, el;

    initial begin
        checks = 0; failures = 0; bd_we = 0; bd_idx = '0; bd_data = '0;
        rst_n = 1'b0;
        idle_inputs();

        vt[0]  = '{1'b0, 2'b00, 1'b0, 32'h203, 32'h0,      32'h80112233, 32'hFFFFFF80, 1'b0, 3, 8'h02, 32'h0};
        vt[1]  = '{1'b0, 2'b00, 1'b1, 32'h203, 32'h0,      32'h80112233, 32'h00000080, 1'b0, 3, 8'h02, 32'h0};
        vt[2]  = '{1'b1, 2'b00, 1'b0, 32'h201, 32'h000000AA, 32'h11223344, 32'h0,      1'b0, 4, 8'h0A, 32'h1122AA44};
        vt[3]  = '{1'b1, 2'b01, 1'b0, 32'h203, 32'h00001234, 32'h11223344, 32'h0,      1'b1, 1, 8'h00, 32'h0};
        vt[4]  = '{1'b0, 2'b01, 1'b0, 32'h206, 32'h0,      32'h80017FFF, 32'hFFFF8001, 1'b0, 3, 8'h02, 32'h0};
        vt[5]  = '{1'b0, 2'b01, 1'b1, 32'h206, 32'h0,      32'h80017FFF, 32'h00008001, 1'b0, 3, 8'h02, 32'h0};
        vt[6]  = '{1'b0, 2'b10, 1'b0, 32'h208, 32'h0,      32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 3, 8'h02, 32'h0};
        vt[7]  = '{1'b1, 2'b10, 1'b0, 32'h20C, 32'h12345678, 32'h0,      32'h0,        1'b0, 2, 8'h02, 32'h12345678};
        vt[8]  = '{1'b0, 2'b11, 1'b0, 32'h210, 32'h0,      32'h55555555, 32'h0,        1'b1, 1, 8'h00, 32'h0};
        vt[9]  = '{1'b0, 2'b10, 1'b0, 32'h212, 32'h0,      32'h55555555, 32'h0,        1'b1, 1, 8'h00, 32'h0};
        vt[10] = '{1'b1, 2'b01, 1'b0, 32'h216, 32'h0000BEEF, 32'h11223344, 32'h0,      1'b0, 4, 8'h0A, 32'hBEEF3344};
        vt[11] = '{1'b0, 2'b00, 1'b0, 32'h221, 32'h0,      32'h00007F00, 32'h0000007F, 1'b0, 3, 8'h02, 32'h0};

        // reset state
        repeat (2) @(negedge clk);
        chk("reset_ctl", {bus0.if_gnt, bus0.d_gnt, bus0.if_valid, bus0.d_valid,
                          bus0.if_err, bus0.d_err, bus0.mem_en, bus0.mem_rw}, 32'h0);
        chk("reset_data", bus0.if_rdata | bus0.d_rdata | bus0.mem_wdata | bus0.mem_addr, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // fetch of a word
        preload(32'h100 >> 2, 32'hDEADBEEF);
        txn(1, 0, 2'b10, 0, 32'h100, 32'h0, lat, rd, er, enm, ww);
        chk("fetch_lat", lat, 3);
        chk("fetch_data", rd, 32'hDEADBEEF);
        chk("fetch_err", er, 0);
        chk("fetch_en", enm, 8'h02);

        // misaligned fetch
        txn(1, 0, 2'b10, 0, 32'h102, 32'h0, lat, rd, er, enm, ww);
        chk("fetch_mis_lat", lat, 1);
        chk("fetch_mis_err", er, 1);
        chk("fetch_mis_en", enm, 8'h00);

        // directed table
        for (int i = 0; i < 12; i++) begin
            preload(int'(vt[i].addr[11:2]), vt[i].pre);
            txn(0, vt[i].we, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wd, lat, rd, er, enm, ww);
            chk($sformatf("vec%0d_lat", i), lat, vt[i].elat);
            chk($sformatf("vec%0d_err", i), er, vt[i].eer);
            chk($sformatf("vec%0d_en", i), enm, vt[i].eenm);
            chk($sformatf("vec%0d_wr", i), ww, vt[i].eww);
            if (!vt[i].we || vt[i].eer) chk($sformatf("vec%0d_rdata", i), rd, vt[i].erd);
        end

        // arbitration with both ports requesting continuously
        do_reset();
        bus0.if_req = 1; bus0.if_addr = 32'h100; bus0.d_req = 1; bus0.d_addr = 32'h104;
        bus1.if_req = 1; bus1.if_addr = 32'h100; bus1.d_req = 1; bus1.d_addr = 32'h104;
        n0 = 0; n1 = 0; nif1 = 0; seq0 = '0; seq1 = '0; c0a = 0; c0b = 0; c1a = 0; c1b = 0;
        for (int c = 0; c < 60 && (n0 < 6 || n1 < 6); c++) begin
            @(negedge clk);
            if (n0 < 6 && (bus0.if_gnt || bus0.d_gnt)) begin
                if (bus0.if_gnt && bus0.d_gnt) chk("arb0_double_gnt", 1, 0);
                seq0 = {seq0[4:0], bus0.d_gnt};
                if (n0 == 0) c0a = c;
                if (n0 == 5) c0b = c;
                n0++;
            end
            if (n1 < 6 && (bus1.if_gnt || bus1.d_gnt)) begin
                if (bus1.if_gnt) nif1++;
                seq1 = {seq1[4:0], bus1.d_gnt};
                if (n1 == 0) c1a = c;
                if (n1 == 5) c1b = c;
                n1++;
            end
        end
        chk("arb0_count", n0, 6);
        chk("arb0_order", seq0, 6'b010101);
        chk("arb0_spacing", c0b - c0a, 15);
        chk("arb1_count", n1, 6);
        chk("arb1_order", seq1, 6'b111111);
        chk("arb1_fetch_gnts", nif1, 0);
        chk("arb1_spacing", c1b - c1a, 15);
        do_reset();

        // reset while a load has mem_en high: the strobe must drop at once
        bus0.d_req = 1; bus0.d_we = 0; bus0.d_size = 2'b10; bus0.d_addr = 32'h100;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = bus0.d_gnt; end
        chk("rst_ld_gnt", got, 1);
        @(posedge clk); #1;
        bus0.d_req = 0;
        chk("rst_ld_en_before", bus0.mem_en, 1);
        rst_n = 1'b0; #1;
        chk("rst_ld_en_drop", bus0.mem_en, 0);
        nv = 0;
        repeat (2) begin @(negedge clk); nv += int'(bus0.d_valid); end
        rst_n = 1'b1;
        repeat (4) begin @(negedge clk); nv += int'(bus0.d_valid); end
        chk("rst_ld_no_valid", nv, 0);
        @(posedge clk); #1;

        // reset at T+2 of a byte RMW store: no write, no completion
        preload(32'h240 >> 2, 32'h55667788);
        bus0.d_req = 1; bus0.d_we = 1; bus0.d_size = 2'b00; bus0.d_addr = 32'h241; bus0.d_wdata = 32'h99;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = bus0.d_gnt; end
        chk("rst_rmw_gnt", got, 1);
        @(posedge clk); #1;
        bus0.d_req = 0; bus0.d_we = 0;
        @(negedge clk);
        chk("rst_rmw_read", {bus0.mem_en, bus0.mem_rw}, 2'b10);
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        chk("rst_rmw_en", bus0.mem_en, 0);
        nv = 0; ne = 0;
        repeat (2) begin @(negedge clk); nv += int'(bus0.d_valid); ne += int'(bus0.mem_en); end
        rst_n = 1'b1;
        repeat (5) begin @(negedge clk); nv += int'(bus0.d_valid); ne += int'(bus0.mem_en); end
        chk("rst_rmw_no_valid", nv, 0);
        chk("rst_rmw_no_access", ne, 0);
        chk("rst_rmw_mem", mem0[32'h240 >> 2], 32'h55667788);
        @(posedge clk); #1;
        txn(1, 0, 2'b10, 0, 32'h100, 32'h0, lat, rd, er, enm, ww);
        chk("post_rst_fetch_lat", lat, 3);
        chk("post_rst_fetch_data", rd, 32'hDEADBEEF);

        // randomized traffic against the reference model
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            ref_mem[i] = w;
            preload(i, w);
        end
        for (int t = 0; t < 120; t++) begin
            fe = ($urandom_range(0, 4) == 0);
            if (fe) begin
                a = $urandom_range(0, 63) * 4;
                if ($urandom_range(0, 3) == 0) a += $urandom_range(1, 3);
                sz = 2'b10; we = 0; uns = 0; w = 32'h0;
            end else begin
                a = $urandom_range(0, 255);
                sz = 2'($urandom_range(0, 3)); we = $urandom_range(0, 1) != 0;
                uns = $urandom_range(0, 1) != 0; w = $urandom;
            end
            eer = ref_err(sz, a);
            expd = 32'h0;
            if (eer) el = 1;
            else if (!we) begin
                el = 3;
                expd = ref_load(ref_mem[a / 4], sz, uns, a % 4);
            end else if (sz == 2'b10) begin
                el = 2;
                ref_mem[a / 4] = w;
            end else begin
                el = 4;
                expd = (sz == 2'b00) ? 32'hFF : 32'hFFFF;
                ref_mem[a / 4] = (ref_mem[a / 4] & ~(expd << (8 * (a % 4))))
                               | ((w & expd) << (8 * (a % 4)));
                expd = 32'h0;
            end
            txn(fe, we, sz, uns, 32'(a), w, lat, rd, er, enm, ww);
            chk($sformatf("rnd%0d_lat", t), lat, el);
            chk($sformatf("rnd%0d_err", t), er, eer);
            if (!we || eer) chk($sformatf("rnd%0d_rdata", t), rd, expd);
        end
        for (int i = 0; i < 64; i++) chk($sformatf("rnd_mem%0d", i), mem0[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
